// File: rtl/nios_system_step_sequencer.sv
`default_nettype none
// =============================================================================
// Module : nios_system_step_sequencer
// Brief  : Avalon-MM programmable drum-style step sequencer with trigger lanes
// Rev    : 1.0
// =============================================================================
module nios_system_step_sequencer #(
  parameter int STEPS  = 16,
  parameter int VOICES = 8,
  parameter int DIV_W  = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [VOICES-1:0] trig_out,
  output logic [3:0]        step_idx,
  output logic              irq
);

  localparam logic [4:0] c_addr_ctrl   = 5'd0;
  localparam logic [4:0] c_addr_div    = 5'd1;
  localparam logic [4:0] c_addr_len    = 5'd2;
  localparam logic [4:0] c_addr_status = 5'd3;
  localparam logic [4:0] c_len_max     = 5'(STEPS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [3:0]         r_step, w_step_nxt;
  logic [DIV_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_pend, w_pend_nxt;
  logic               r_wrap, w_wrap_nxt;
  logic [VOICES-1:0]  r_trig, w_trig_nxt;
  logic [31:0]        r_readdata, w_rd_mux;
  logic [DIV_W-1:0]   r_divider;
  logic [4:0]         r_length;
  logic               r_irq_en;
  logic [VOICES-1:0]  r_pattern [STEPS];

  logic               w_wr, w_wr_ctrl, w_wr_div, w_clr_wrap;
  logic               w_start, w_pause, w_stop;
  logic               w_fire, w_wrap_set;
  logic [3:0]         w_fire_step, w_step_adv;
  logic [DIV_W-1:0]   w_div_last;
  logic [4:0]         w_eff_len;
  logic               w_unused;

  assign w_wr       = chipselect & ~write_n;
  assign w_wr_ctrl  = w_wr & (address == c_addr_ctrl);
  assign w_wr_div   = w_wr & (address == c_addr_div);
  assign w_clr_wrap = w_wr & (address == c_addr_status) & writedata[0];
  assign w_start    = w_wr_ctrl & (writedata[1:0] == 2'b01);
  assign w_pause    = w_wr_ctrl & (writedata[1:0] == 2'b10);
  assign w_stop     = w_wr_ctrl & (writedata[1:0] == 2'b11);
  assign w_unused   = ^writedata;

  // A zero divider is treated as one: tick every cycle.
  assign w_div_last = (r_divider == '0) ? '0 : r_divider - DIV_W'(1);
  assign w_eff_len  = ((r_length != 5'd0) && (r_length <= c_len_max)) ? r_length : c_len_max;
  assign w_step_adv = ({1'b0, r_step} >= (w_eff_len - 5'd1)) ? 4'd0 : r_step + 4'd1;

  // Bus commands written this cycle take precedence over the sequencer advance.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    w_fire      = 1'b0;
    w_fire_step = r_step;
    w_wrap_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_RUN;
          w_step_nxt  = 4'd0;
          w_cnt_nxt   = '0;
          w_pend_nxt  = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_pause) begin
          w_state_nxt = ST_PAUSED;
          w_pend_nxt  = 1'b0;
        end else if (r_pend) begin
          w_pend_nxt = 1'b0;
          w_fire     = 1'b1;
        end else if (r_cnt == w_div_last) begin
          w_step_nxt  = w_step_adv;
          w_cnt_nxt   = '0;
          w_fire      = 1'b1;
          w_fire_step = w_step_adv;
          w_wrap_set  = (w_step_adv == 4'd0);
        end else begin
          w_cnt_nxt = r_cnt + DIV_W'(1);
        end
      end
      ST_PAUSED: begin
        if (w_start) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_stop) begin
      w_state_nxt = ST_IDLE;
      w_step_nxt  = 4'd0;
      w_cnt_nxt   = '0;
      w_pend_nxt  = 1'b0;
      w_fire      = 1'b0;
      w_wrap_set  = 1'b0;
    end
    if (w_wr_div) w_cnt_nxt = '0;
    w_wrap_nxt = w_wrap_set | (r_wrap & ~w_clr_wrap);
    w_trig_nxt = w_fire ? r_pattern[w_fire_step] : '0;
  end

  always_comb begin
    w_rd_mux = '0;
    if (address[4]) begin
      w_rd_mux[VOICES-1:0] = r_pattern[address[3:0]];
    end else begin
      case (address)
        c_addr_ctrl:   w_rd_mux[2]         = r_irq_en;
        c_addr_div:    w_rd_mux[DIV_W-1:0] = r_divider;
        c_addr_len:    w_rd_mux[4:0]       = r_length;
        c_addr_status: w_rd_mux[7:0]       = {r_step, 1'b0, r_state, r_wrap};
        default:       w_rd_mux            = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_step     <= 4'd0;
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_wrap     <= 1'b0;
      r_trig     <= '0;
      r_readdata <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_step     <= w_step_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pend     <= w_pend_nxt;
      r_wrap     <= w_wrap_nxt;
      r_trig     <= w_trig_nxt;
      r_readdata <= w_rd_mux;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_divider <= '0;
      r_length  <= c_len_max;
      r_irq_en  <= 1'b0;
      for (int i = 0; i < STEPS; i++) r_pattern[i] <= '0;
    end else if (w_wr) begin
      if (address[4]) r_pattern[address[3:0]] <= writedata[VOICES-1:0];
      else if (address == c_addr_ctrl) r_irq_en <= writedata[2];
      else if (address == c_addr_div) r_divider <= writedata[DIV_W-1:0];
      else if (address == c_addr_len) r_length <= writedata[4:0];
    end
  end

  assign readdata = r_readdata;
  assign trig_out = r_trig;
  assign step_idx = r_step;
  assign irq      = r_wrap & r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_nios_system_step_sequencer.sv
`default_nettype none
// =============================================================================
// Module : tb_nios_system_step_sequencer
// Brief  : Self-checking bench for the step sequencer against a cycle model
// Rev    : 1.0
// =============================================================================
module tb_nios_system_step_sequencer;

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2;

  logic        clk, reset, chipselect, write_n;
  logic [4:0]  address;
  logic [31:0] writedata, readdata;
  logic [7:0]  trig_out;
  logic [3:0]  step_idx;
  logic        irq;

  int n_total = 0;
  int n_bad   = 0;

  int          m_state, m_step, m_cnt, m_div, m_len;
  bit          m_pend, m_wrap, m_irqen;
  logic [7:0]  m_pat [16];
  logic [7:0]  m_trig;
  logic [31:0] m_rd;

  nios_system_step_sequencer #(.STEPS(16), .VOICES(8), .DIV_W(24)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .trig_out(trig_out), .step_idx(step_idx), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_step = 0; m_cnt = 0; m_div = 0; m_len = 16;
    m_pend = 0; m_wrap = 0; m_irqen = 0; m_trig = '0; m_rd = '0;
    for (int i = 0; i < 16; i++) m_pat[i] = '0;
  endtask

  // One rising edge of the behavioural sequencer, using pre-edge bus inputs.
  task automatic model_edge();
    bit wr, fire, wset;
    int a, cmd, eff_len, period;
    logic [31:0] d;
    wr  = chipselect && !write_n;
    a   = int'(address);
    d   = writedata;
    cmd = (wr && a == 0) ? int'(d[1:0]) : 0;
    if (a >= 16)     m_rd = {24'b0, m_pat[a-16]};
    else if (a == 0) m_rd = {29'b0, m_irqen, 2'b0};
    else if (a == 1) m_rd = 32'(m_div);
    else if (a == 2) m_rd = 32'(m_len);
    else if (a == 3) m_rd = 32'(m_step * 16 + m_state * 2 + int'(m_wrap));
    else             m_rd = '0;
    eff_len = (m_len >= 1 && m_len <= 16) ? m_len : 16;
    period  = (m_div == 0) ? 1 : m_div;
    fire = 0; wset = 0;
    if (cmd == 3) begin
      m_state = S_IDLE; m_step = 0; m_cnt = 0; m_pend = 0;
    end else if (m_state == S_RUN && cmd == 2) begin
      m_state = S_PAUSED; m_pend = 0;
    end else if (m_state == S_IDLE) begin
      if (cmd == 1) begin m_state = S_RUN; m_step = 0; m_cnt = 0; m_pend = 1; end
    end else if (m_state == S_PAUSED) begin
      if (cmd == 1) m_state = S_RUN;
    end else if (m_pend) begin
      m_pend = 0; fire = 1;
    end else if (m_cnt + 1 == period) begin
      m_step = (m_step >= eff_len - 1) ? 0 : m_step + 1;
      m_cnt = 0; fire = 1; wset = (m_step == 0);
    end else begin
      m_cnt++;
    end
    if (wr && a == 1) m_cnt = 0;
    m_trig = fire ? m_pat[m_step] : 8'h00;
    m_wrap = wset || (m_wrap && !(wr && a == 3 && d[0]));
    if (wr) begin
      if (a >= 16)     m_pat[a-16] = d[7:0];
      else if (a == 0) m_irqen = d[2];
      else if (a == 1) m_div = int'(d[23:0]);
      else if (a == 2) m_len = int'(d[4:0]);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    model_edge();
    #1;
    check_val("trig", {24'b0, trig_out}, {24'b0, m_trig});
    check_val("step", {28'b0, step_idx}, 32'(m_step));
    check_val("irq", {31'b0, irq}, {31'b0, (m_wrap && m_irqen)});
    check_val("rd", readdata, m_rd);
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick_clk();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    #23;
    check_val("rst_trig", {24'b0, trig_out}, 32'h0);
    check_val("rst_step", {28'b0, step_idx}, 32'h0);
    check_val("rst_irq", {31'b0, irq}, 32'h0);
    check_val("rst_rd", readdata, 32'h0);
    reset = 1'b0;
    address = 5'd2;
    tick_clk();
    check_val("rst_len", readdata, 32'd16);

    // Two-step pattern, divider 4
    bus_write(5'd16, 32'h01);
    bus_write(5'd17, 32'h82);
    bus_write(5'd1, 32'd4);
    bus_write(5'd2, 32'd2);
    bus_write(5'd0, 32'h1);
    tick_clk();
    check_val("pat_first", {24'b0, trig_out}, 32'h01);
    repeat (3) begin tick_clk(); check_val("pat_gap", {24'b0, trig_out}, 32'h0); end
    tick_clk();
    check_val("pat_second", {24'b0, trig_out}, 32'h82);
    repeat (3) tick_clk();
    tick_clk();
    check_val("pat_third", {24'b0, trig_out}, 32'h01);
    address = 5'd3;
    tick_clk();
    check_val("pat_wrap", {31'b0, readdata[0]}, 32'h1);
    bus_write(5'd0, 32'h3);
    bus_write(5'd3, 32'h1);

    // Interrupt on wrap, clear, and clear coincident with wrap
    bus_write(5'd0, 32'h4);
    bus_write(5'd1, 32'd1);
    bus_write(5'd2, 32'd3);
    bus_write(5'd0, 32'h5);
    repeat (3) begin tick_clk(); check_val("irq_low", {31'b0, irq}, 32'h0); end
    tick_clk();
    check_val("irq_rise", {31'b0, irq}, 32'h1);
    bus_write(5'd3, 32'h1);
    check_val("irq_clear", {31'b0, irq}, 32'h0);
    tick_clk();
    bus_write(5'd3, 32'h1);
    check_val("irq_coincident", {31'b0, irq}, 32'h1);
    bus_write(5'd0, 32'h3);
    bus_write(5'd3, 32'h1);
    bus_write(5'd0, 32'h0);

    // Pause at step 5 and resume
    bus_write(5'd1, 32'd3);
    bus_write(5'd2, 32'd16);
    bus_write(5'd0, 32'h1);
    for (int k = 0; k < 200 && !(m_step == 5 && m_cnt == 1); k++) tick_clk();
    check_val("pause_reach", 32'(m_step == 5 && m_cnt == 1), 32'h1);
    bus_write(5'd0, 32'h2);
    repeat (20) begin
      tick_clk();
      check_val("pause_step", {28'b0, step_idx}, 32'd5);
      check_val("pause_trig", {24'b0, trig_out}, 32'h0);
    end
    bus_write(5'd0, 32'h1);
    tick_clk();
    check_val("resume_hold", {28'b0, step_idx}, 32'd5);
    tick_clk();
    check_val("resume_adv", {28'b0, step_idx}, 32'd6);
    bus_write(5'd0, 32'h3);

    // Zero divider, out-of-range lengths give 16-step wrap
    for (int t = 0; t < 2; t++) begin
      bus_write(5'd1, 32'd0);
      bus_write(5'd2, (t == 0) ? 32'd0 : 32'd20);
      bus_write(5'd0, 32'h1);
      tick_clk();
      for (int i = 1; i <= 20; i++) begin
        tick_clk();
        check_val("len16_step", {28'b0, step_idx}, 32'(i % 16));
      end
      bus_write(5'd0, 32'h3);
    end

    // STATUS read in RUN at step 3, unmapped read
    bus_write(5'd1, 32'd50);
    bus_write(5'd2, 32'd16);
    bus_write(5'd0, 32'h1);
    for (int k = 0; k < 400 && m_step != 3; k++) tick_clk();
    check_val("status_reach", 32'(m_step), 32'd3);
    bus_write(5'd3, 32'h1);
    address = 5'd3;
    tick_clk();
    check_val("status_run3", readdata, 32'h32);
    address = 5'd7;
    tick_clk();
    check_val("addr7", readdata, 32'h0);

    // Asynchronous reset while a trigger pulse is on the output
    bus_write(5'd0, 32'h3);
    bus_write(5'd1, 32'd1);
    bus_write(5'd0, 32'h1);
    for (int k = 0; k < 40 && m_trig == 8'h00; k++) tick_clk();
    check_val("arst_trig_active", 32'(trig_out != 8'h00), 32'h1);
    #3 reset = 1'b1;
    #1;
    check_val("arst_trig", {24'b0, trig_out}, 32'h0);
    check_val("arst_step", {28'b0, step_idx}, 32'h0);
    check_val("arst_irq", {31'b0, irq}, 32'h0);
    check_val("arst_rd", readdata, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    address = 5'd3;
    repeat (3) tick_clk();
    check_val("arst_idle", readdata, 32'h0);

    // Randomized bus traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 25) begin
        case ($urandom_range(0, 5))
          0: begin address = 5'd0; writedata = $urandom; end
          1: begin address = 5'd1; writedata = $urandom_range(0, 4); end
          2: begin address = 5'd2; writedata = $urandom_range(0, 20); end
          3: begin address = 5'd3; writedata = $urandom; end
          4: begin address = 5'(16 + $urandom_range(0, 15)); writedata = $urandom; end
          default: begin address = 5'($urandom_range(4, 15)); writedata = $urandom; end
        endcase
        chipselect = 1'b1; write_n = 1'b0;
      end else begin
        address    = 5'($urandom_range(0, 31));
        writedata  = $urandom;
        chipselect = 1'($urandom_range(0, 1));
        write_n    = chipselect ? 1'b1 : 1'($urandom_range(0, 1));
      end
      tick_clk();
      chipselect = 1'b0; write_n = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
